// File: rtl/dcache_pkg.sv
// Geometry, FSM states and tag-entry layout shared by the data cache controller
// and its storage array.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned NUM_SETS   = 16;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned IDX_W      = $clog2(NUM_SETS);
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFFSET_W;
  localparam int unsigned WORD_SEL_W = $clog2(LINE_W / DATA_W);
  localparam int unsigned BIT_SEL_W  = $clog2(DATA_W);
  localparam int unsigned LINE_BIT_W = WORD_SEL_W + BIT_SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    DONE
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/dcache_sram.sv
// Per-set tag entry and data line storage: asynchronous read, synchronous write,
// valid/dirty cleared by reset.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              wr_en_i,
  input  tag_entry_t        wr_entry_i,
  input  logic [LINE_W-1:0] wr_line_i,
  output tag_entry_t        rd_entry_o,
  output logic [LINE_W-1:0] rd_line_o
);

  tag_entry_t        entry_q [NUM_SETS];
  logic [LINE_W-1:0] line_q  [NUM_SETS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        entry_q[s] <= '0;
      end
    end else if (wr_en_i) begin
      entry_q[idx_i] <= wr_entry_i;
    end
  end

  // Line payload carries no reset; it is only observed behind a valid entry.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      line_q[idx_i] <= wr_line_i;
    end
  end

  assign rd_entry_o = entry_q[idx_i];
  assign rd_line_o  = line_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller: zero-latency
// hits, FSM-sequenced line writeback/refill against a 256-bit memory port.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic [LINE_BIT_W-1:0] word_lsb;
  logic                  hit;
  logic                  unused_addr_bits;

  tag_entry_t            rd_entry;
  tag_entry_t            wr_entry;
  logic [LINE_W-1:0]     rd_line;
  logic [LINE_W-1:0]     wr_line;
  logic                  wr_en;

  state_e                state_q, state_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]     mem_data_q, mem_data_d;

  assign idx              = cpu_addr_i[OFFSET_W +: IDX_W];
  assign req_tag          = cpu_addr_i[OFFSET_W + IDX_W +: TAG_W];
  assign word_sel         = cpu_addr_i[2 +: WORD_SEL_W];
  assign word_lsb         = {word_sel, {BIT_SEL_W{1'b0}}};
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign hit              = cpu_req_i & rd_entry.valid & (rd_entry.tag == req_tag);

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx),
    .wr_en_i    (wr_en),
    .wr_entry_i (wr_entry),
    .wr_line_i  (wr_line),
    .rd_entry_o (rd_entry),
    .rd_line_o  (rd_line)
  );

  // Next state, array write port, and the memory request registered for the next state.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    wr_en        = 1'b0;
    wr_entry     = rd_entry;
    wr_line      = rd_line;
    cpu_stall_o  = 1'b1;
    cpu_data_o   = '0;

    unique case (state_q)
      IDLE: begin
        cpu_stall_o = cpu_req_i & ~hit;
        if (hit) begin
          if (cpu_write_i) begin
            wr_en                        = 1'b1;
            wr_entry.dirty               = 1'b1;
            wr_line[word_lsb +: DATA_W]  = cpu_data_i;
          end else begin
            cpu_data_o = rd_line[word_lsb +: DATA_W];
          end
        end else if (cpu_req_i) begin
          mem_enable_d = 1'b1;
          if (rd_entry.valid & rd_entry.dirty) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {rd_entry.tag, idx, {OFFSET_W{1'b0}}};
            mem_data_d  = rd_line;
          end else begin
            state_d     = REFILL;
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, idx, {OFFSET_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = REFILL;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag, idx, {OFFSET_W{1'b0}}};
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          state_d        = DONE;
          mem_enable_d   = 1'b0;
          mem_write_d    = 1'b0;
          wr_en          = 1'b1;
          wr_entry.valid = 1'b1;
          wr_entry.dirty = 1'b0;
          wr_entry.tag   = req_tag;
          wr_line        = mem_data_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    // Reset forces the CPU-side outputs quiet even while a request is held.
    if (rst_i) begin
      cpu_stall_o = 1'b0;
      cpu_data_o  = '0;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: the bench plays the memory, keeps a set-level cache model
// and checks DUT outputs every cycle at the falling edge.
module tb_dcache_controller;

  logic         clk_i;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Cache model: per set valid/dirty/tag and eight words.
  bit           m_valid [16];
  bit           m_dirty [16];
  int unsigned  m_tag   [16];
  logic [31:0]  m_word  [16][8];
  logic [255:0] backing [int unsigned];

  int           wb_count = 0;
  logic [31:0]  last_wb_addr;
  logic [255:0] last_wb_line;
  int unsigned  force_lat = 0;

  bit           exp_on = 1'b0;
  logic         exp_stall, exp_men, exp_mwr;
  logic [31:0]  exp_data, exp_maddr;
  logic [255:0] exp_mline;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_exp(input logic stall, input logic [31:0] data, input logic men,
                         input logic mwr, input logic [31:0] maddr, input logic [255:0] mline);
    exp_stall = stall;
    exp_data  = data;
    exp_men   = men;
    exp_mwr   = mwr;
    exp_maddr = maddr;
    exp_mline = mline;
  endtask

  always @(negedge clk_i) begin
    if (exp_on && !rst_i) begin
      check("cpu_stall", 256'(cpu_stall_o), 256'(exp_stall));
      check("cpu_data", 256'(cpu_data_o), 256'(exp_data));
      check("mem_enable", 256'(mem_enable_o), 256'(exp_men));
      if (exp_men) begin
        check("mem_write", 256'(mem_write_o), 256'(exp_mwr));
        check("mem_addr", 256'(mem_addr_o), 256'(exp_maddr));
        if (exp_mwr) check("mem_data", mem_data_o, exp_mline);
      end
    end
  end

  // CPU inputs must not move while the previous cycle was stalled.
  logic [65:0] prev_in;
  bit          prev_stall = 1'b0;
  always @(negedge clk_i) begin
    if (!rst_i && prev_stall)
      check("stall_contract", 256'({cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i}), 256'(prev_in));
    prev_stall = cpu_stall_o && !rst_i;
    prev_in    = {cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i};
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ 32'hA5A5_0000 ^ (32'(w) << 24);
    return l;
  endfunction

  function automatic logic [255:0] pack_set(input int unsigned s);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = m_word[s][w];
    return l;
  endfunction

  function automatic int unsigned pick_lat();
    return (force_lat != 0) ? force_lat : $urandom_range(1, 6);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 16; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  task automatic step_sample(output logic [31:0] d);
    @(negedge clk_i);
    #1 d = cpu_data_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    logic [31:0] dummy;
    cpu_req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_exp(1'b0, '0, 1'b0, 1'b0, '0, '0);
      step_sample(dummy);
    end
  endtask

  task automatic reset_dut();
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
    idle(1);
  endtask

  // One CPU access from issue to the cycle it completes as a hit.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output bit missed);
    int unsigned  idx, tag, w, lat;
    logic [31:0]  la, va;
    logic [255:0] vl, nl;
    idx = (addr >> 5) & 32'hF;
    tag = addr >> 9;
    w   = (addr >> 2) & 32'h7;
    la  = addr & 32'hFFFF_FFE0;
    missed = !(m_valid[idx] && m_tag[idx] == tag);
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    if (missed) begin
      set_exp(1'b1, '0, 1'b0, 1'b0, '0, '0);
      step_sample(rdata);
      if (m_valid[idx] && m_dirty[idx]) begin
        va  = 32'((m_tag[idx] << 9) | (idx << 5));
        vl  = pack_set(idx);
        lat = pick_lat();
        for (int c = 0; c < int'(lat); c++) begin
          set_exp(1'b1, '0, 1'b1, 1'b1, va, vl);
          mem_ack_i = (c == int'(lat) - 1);
          step_sample(rdata);
        end
        mem_ack_i = 1'b0;
        backing[va]  = vl;
        wb_count++;
        last_wb_addr = va;
        last_wb_line = vl;
      end
      nl  = get_line(la);
      lat = pick_lat();
      for (int c = 0; c < int'(lat); c++) begin
        set_exp(1'b1, '0, 1'b1, 1'b0, la, '0);
        mem_ack_i  = (c == int'(lat) - 1);
        mem_data_i = (c == int'(lat) - 1) ? nl : rand_line();
        step_sample(rdata);
      end
      mem_ack_i  = 1'b0;
      mem_data_i = rand_line();
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      for (int k = 0; k < 8; k++) m_word[idx][k] = nl[k*32 +: 32];
      set_exp(1'b1, '0, 1'b0, 1'b0, '0, '0);
      step_sample(rdata);
    end
    set_exp(1'b0, wr ? 32'h0 : m_word[idx][w], 1'b0, 1'b0, '0, '0);
    if (wr) begin
      m_word[idx][w] = wdata;
      m_dirty[idx]   = 1'b1;
    end
    step_sample(rdata);
  endtask

  initial begin
    logic [31:0]  rd;
    logic [31:0]  addr;
    logic [255:0] l40;
    bit           ms;
    int           wb_before;

    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = rand_line();
    set_exp(1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int w = 0; w < 8; w++) l40[w*32 +: 32] = 32'(w + 1) * 32'h1111_1111;
    backing[32'h40] = l40;
    model_clear();

    @(posedge clk_i); #1;
    check("rst_stall", 256'(cpu_stall_o), 256'(0));
    check("rst_cpu_data", 256'(cpu_data_o), 256'(0));
    check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
    check("rst_mem_write", 256'(mem_write_o), 256'(0));
    check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    check("rst_mem_data", mem_data_o, 256'(0));
    @(posedge clk_i); #1;
    rst_i  = 1'b0;
    exp_on = 1'b1;
    idle(2);

    // Cold read miss with a 10-cycle refill.
    force_lat = 10;
    do_access(1'b0, 32'h40, '0, rd, ms);
    force_lat = 0;
    check("cold_missed", 256'(ms), 256'(1));
    check("cold_load", 256'(rd), 256'(32'h1111_1111));
    check("cold_no_wb", 256'(wb_count), 256'(0));
    idle(1);

    do_access(1'b0, 32'h44, '0, rd, ms);
    check("hit_missed", 256'(ms), 256'(0));
    check("hit_load", 256'(rd), 256'(32'h2222_2222));

    do_access(1'b1, 32'h48, 32'hDEAD_BEEF, rd, ms);
    check("whit_missed", 256'(ms), 256'(0));
    do_access(1'b0, 32'h48, '0, rd, ms);
    check("whit_load", 256'(rd), 256'(32'hDEAD_BEEF));
    check("set2_dirty", 256'(m_dirty[2]), 256'(1));
    idle(1);

    // Dirty conflict in set 2.
    do_access(1'b0, 32'h240, '0, rd, ms);
    check("conf_missed", 256'(ms), 256'(1));
    check("conf_wb_count", 256'(wb_count), 256'(1));
    check("conf_wb_addr", 256'(last_wb_addr), 256'(32'h40));
    check("conf_wb_word2", 256'(last_wb_line[95:64]), 256'(32'hDEAD_BEEF));
    check("conf_load", 256'(rd), 256'(32'hA5A5_0240));

    // Clean write miss into invalid set 3.
    wb_before = wb_count;
    do_access(1'b1, 32'h60, 32'h1234_5678, rd, ms);
    check("wmiss_missed", 256'(ms), 256'(1));
    check("wmiss_no_wb", 256'(wb_count - wb_before), 256'(0));
    do_access(1'b0, 32'h60, '0, rd, ms);
    check("wmiss_load", 256'(rd), 256'(32'h1234_5678));

    // Written-back data comes back from memory after eviction.
    do_access(1'b0, 32'h48, '0, rd, ms);
    check("evict_missed", 256'(ms), 256'(1));
    check("evict_load", 256'(rd), 256'(32'hDEAD_BEEF));
    check("evict_clean_victim", 256'(wb_count), 256'(1));

    for (int i = 0; i < 250; i++) begin
      addr = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
                 ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      do_access(($urandom_range(0, 9) < 4), addr, $urandom, rd, ms);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    // Reset in the middle of a refill, then a stale ack.
    reset_dut();
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h40; cpu_data_i = '0;
    set_exp(1'b1, '0, 1'b0, 1'b0, '0, '0);
    step_sample(rd);
    for (int c = 0; c < 2; c++) begin
      set_exp(1'b1, '0, 1'b1, 1'b0, 32'h40, '0);
      step_sample(rd);
    end
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    #1;
    check("midrst_mem_enable", 256'(mem_enable_o), 256'(0));
    check("midrst_stall", 256'(cpu_stall_o), 256'(0));
    check("midrst_cpu_data", 256'(cpu_data_o), 256'(0));
    model_clear();
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    mem_ack_i = 1'b1;
    set_exp(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step_sample(rd);
    mem_ack_i = 1'b0;
    idle(2);
    do_access(1'b0, 32'h40, '0, rd, ms);
    check("postrst_missed", 256'(ms), 256'(1));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the pipeline MEM stage (EX_MEM address, write data and MemRead/MemWrite) and a slow off-chip data memory with a 256-bit line interface.
- Serves hits with zero added latency.
- Sequences line writeback and refill on misses, and stalls the whole pipeline while memory is busy.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- DATA_W, 32, CPU word width.
- LINE_W, 256, cache line width in bits (32 bytes, 8 words).
- NUM_SETS, 16, number of sets. IDX_W = log2(NUM_SETS). TAG_W = ADDR_W - IDX_W - 5.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cpu_req_i  in  1  access valid (MemRead | MemWrite)
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  byte address; [1:0] ignored
- cpu_data_i  in  DATA_W  store data
- cpu_data_o  out  DATA_W  load data
- cpu_stall_o  out  1  hold PC, IF_ID, ID_EX, EX_MEM, MEM_WB
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = line write, 0 = line read
- mem_addr_o  out  ADDR_W  line address, [4:0] = 0
- mem_data_o  out  LINE_W  writeback line
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - offset = addr[4:0]; word select = addr[4:2]
  - index = addr[IDX_W+4:5]
  - tag = addr[ADDR_W-1:IDX_W+5]
- Per set: valid, dirty, tag, line.
- hit = cpu_req_i & valid[index] & (tag == stored tag). Combinational.
- Reset (asynchronous, any state):
  - state = IDLE; all valid and dirty bits = 0.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - cpu_stall_o = 0, cpu_data_o = 0.
  - A mem_ack_i arriving after reset is ignored.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
- IDLE:
  - cpu_stall_o = cpu_req_i & ~hit.
  - Read hit: cpu_data_o = selected word in the same cycle.
  - Write hit: at the clock edge, write the word into the line and set dirty = 1.
  - Miss: if victim is valid & dirty, go to WRITEBACK; otherwise go to REFILL.
  - cpu_data_o = 0 when there is no read hit.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - On mem_ack_i, go to REFILL.
- REFILL:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i: line = mem_data_i, tag = req tag, valid = 1, dirty = 0; go to DONE.
- DONE: one cycle, then IDLE. The access then re-evaluates as a hit; a write-allocate store completes there.
- cpu_stall_o = 1 in WRITEBACK, REFILL and DONE.
- Memory handshake:
  - mem_enable_o and address/data are held stable until the cycle mem_ack_i is sampled.
  - mem_enable_o drops (or switches request type) the following cycle.
  - Memory latency is unbounded.
  - mem_ack_i is ignored in IDLE and DONE.
- Miss penalty, clean victim: 1 (miss detect) + refill latency + 1 (DONE) cycles.
- Miss penalty, dirty victim: additionally adds the writeback latency.
- Stall contract: cpu_req_i, cpu_write_i, cpu_addr_i and cpu_data_i stay constant while cpu_stall_o = 1. Violation is a pipeline bug; the bench asserts on it.
- Write data lands in bits [32*w+31 : 32*w] for word w.

Decomposition:
- Package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, REFILL, DONE);
  - the OFFSET_W = 5 constant;
  - the tag-entry struct {valid, dirty, tag}.
- One sub-module, dcache_sram:
  - NUM_SETS x (tag entry + LINE_W) storage;
  - asynchronous read, synchronous write;
  - valid/dirty cleared by rst_i.
- The FSM and hit/word-merge logic stay in dcache_controller.

Test Plan:
- Cold read miss:
  - Stimulus: reset, then load 0x0000_0040; memory acks after 10 cycles with word0 = 0x1111_1111.
  - Response: stall rises same cycle; REFILL presents mem_addr_o = 0x40 with mem_write_o = 0; DONE; next IDLE cycle cpu_data_o = 0x1111_1111, stall = 0.
- Read hit:
  - Stimulus: load 0x0000_0044.
  - Response: word1 of the refilled line returned the same cycle; mem_enable_o stays 0; stall stays 0.
- Write hit:
  - Stimulus: store 0xDEAD_BEEF to 0x0000_0048, then load 0x48.
  - Response: the load returns 0xDEAD_BEEF; set 2 is dirty; no memory traffic.
- Dirty conflict:
  - Stimulus: load 0x0000_0240 (index 2, tag 1).
  - Response: WRITEBACK with mem_addr_o = 0x40 and mem_data_o[95:64] = 0xDEAD_BEEF; then REFILL with mem_addr_o = 0x240; data returned after DONE.
- Clean write miss:
  - Stimulus: store 0x1234_5678 to 0x0000_0060 (index 3, invalid set).
  - Response: REFILL only, no WRITEBACK; after DONE the word is merged, dirty = 1; a later load of 0x60 returns 0x1234_5678.
- Reset mid-miss:
  - Stimulus: assert rst_i during REFILL, then pulse mem_ack_i after reset.
  - Response: state IDLE and mem_enable_o = 0 immediately; all lines invalid; the late ack is ignored; the next load of 0x40 misses again.
